// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I sequencer: fetch/decode/exec/mem/wb with memory wait timeout and sticky trap
module multicycle_control #(
  parameter int TIMEOUT   = 16,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [3:0]           inst_type,
  input  logic [4:0]           rd_addr,
  input  logic                 opcode_valid,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 rf_read,
  output logic                 alu_en,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 trap,
  output logic [2:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  // Decoder instruction-type encoding
  localparam logic [3:0] TYPE_ALU    = 4'd0;
  localparam logic [3:0] TYPE_ALUI   = 4'd1;
  localparam logic [3:0] TYPE_LOAD   = 4'd2;
  localparam logic [3:0] TYPE_STORE  = 4'd3;
  localparam logic [3:0] TYPE_BRANCH = 4'd4;
  localparam logic [3:0] TYPE_JAL    = 4'd5;
  localparam logic [3:0] TYPE_JALR   = 4'd6;
  localparam logic [3:0] TYPE_LUI    = 4'd7;
  localparam logic [3:0] TYPE_AUIPC  = 4'd8;
  localparam logic [3:0] TYPE_FENCE  = 4'd9;
  localparam logic [3:0] TYPE_SYSTEM = 4'd10;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int             CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit             TO_EN     = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          wait_cnt;
  logic [2:0]             cause_q, cause_next;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   wait_expired;

  logic is_load, is_store, is_branch, is_fence, is_jump;

  assign is_load      = (inst_type == TYPE_LOAD);
  assign is_store     = (inst_type == TYPE_STORE);
  assign is_branch    = (inst_type == TYPE_BRANCH);
  assign is_fence     = (inst_type == TYPE_FENCE);
  assign is_jump      = (inst_type == TYPE_JAL) || (inst_type == TYPE_JALR);
  assign wait_expired = TO_EN && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    cause_next = 3'd0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    rf_read    = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'd0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    trap       = 1'b0;

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = 3'd1;
        end
      end
      S_DECODE: begin
        rf_read = 1'b1;
        if (!opcode_valid) begin
          state_next = S_TRAP;
          cause_next = 3'd2;
        end else if (opcode == OP_SYSTEM) begin
          state_next = S_TRAP;
          cause_next = 3'd3;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          pc_write   = 1'b1;
          pc_src     = branch_taken;
          state_next = S_FETCH;
        end else if (is_fence) begin
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = 3'd4;
        end
      end
      S_WB: begin
        reg_write  = (rd_addr != 5'd0);
        wb_sel     = is_load ? 2'd1 : is_jump ? 2'd2 : (inst_type == TYPE_LUI) ? 2'd3 : 2'd0;
        pc_write   = 1'b1;
        pc_src     = is_jump;
        state_next = S_FETCH;
      end
      default: begin
        trap = 1'b1;
      end
    endcase

    // Reset overrides everything combinationally so an in-flight request drops immediately
    if (reset) begin
      state_next = S_FETCH;
      cause_next = 3'd0;
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      rf_read    = 1'b0;
      alu_en     = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = 2'd0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      trap       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      cause_q   <= 3'd0;
      instret_q <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + CW'(1);
      if (state_next == S_TRAP && state != S_TRAP)
        cause_q <= cause_next;
      if (pc_write)
        instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign trap_cause = reset ? 3'd0 : cause_q;
  assign instret    = reset ? '0 : instret_q;

  // TYPE_ALU, TYPE_ALUI, TYPE_AUIPC and TYPE_SYSTEM all take the default paths above
  logic unused_types;
  assign unused_types = ^{TYPE_ALU, TYPE_ALUI, TYPE_AUIPC, TYPE_SYSTEM};

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int TIMEOUT = 16;

  localparam int T_ALU = 0, T_ALUI = 1, T_LOAD = 2, T_STORE = 3, T_BRANCH = 4, T_JAL = 5;
  localparam int T_JALR = 6, T_LUI = 7, T_AUIPC = 8, T_FENCE = 9, T_SYSTEM = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [3:0]  inst_type;
  logic [4:0]  rd_addr;
  logic        opcode_valid, branch_taken, imem_ready, dmem_ready;
  logic        imem_req, ir_load, rf_read, alu_en, dmem_req, dmem_we, reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write, pc_src, trap;
  logic [2:0]  trap_cause;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(TIMEOUT), .INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .inst_type(inst_type), .rd_addr(rd_addr),
    .opcode_valid(opcode_valid), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load), .rf_read(rf_read),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  function automatic logic [6:0] op_of(input int t);
    case (t)
      T_ALU:    return 7'h33;
      T_ALUI:   return 7'h13;
      T_LOAD:   return 7'h03;
      T_STORE:  return 7'h23;
      T_BRANCH: return 7'h63;
      T_JAL:    return 7'h6F;
      T_JALR:   return 7'h67;
      T_LUI:    return 7'h37;
      T_AUIPC:  return 7'h17;
      T_FENCE:  return 7'h0F;
      default:  return 7'h73;
    endcase
  endfunction

  task automatic set_instr(input int t, input logic [4:0] rd, input logic tk);
    inst_type    = 4'(t);
    opcode       = op_of(t);
    rd_addr      = rd;
    branch_taken = tk;
    opcode_valid = 1'b1;
  endtask

  // Runs one instruction to retirement; iw/dw are wait cycles before each ready
  task automatic run_instr(input int t, input logic [4:0] rd, input logic tk,
                           input int iw, input int dw, input string nm);
    int cyc = 0, ic = 0, dc = 0, wec = 0, rwc = 0, irl = 0, rfr = 0, alu = 0;
    int exp_cyc, exp_dreq, exp_we, exp_rw, exp_ps, exp_wbs, ps = 0, wbs = 0;
    bit done = 0, is_mem, has_wb, is_jump;
    set_instr(t, rd, tk);
    while (!done && cyc < 100) begin
      imem_ready = (ic == iw);
      dmem_ready = (dc == dw);
      #1;
      cyc++;
      if (imem_req)  ic++;
      if (dmem_req)  dc++;
      if (dmem_we)   wec++;
      if (reg_write) rwc++;
      if (ir_load)   irl++;
      if (rf_read)   rfr++;
      if (alu_en)    alu++;
      if (pc_write) begin done = 1; ps = int'(pc_src); wbs = int'(wb_sel); end
      @(posedge clk); #1;
    end
    is_mem   = (t == T_LOAD || t == T_STORE);
    has_wb   = !(t == T_BRANCH || t == T_FENCE || t == T_STORE);
    is_jump  = (t == T_JAL || t == T_JALR);
    exp_cyc  = iw + 1 + 2 + (is_mem ? dw + 1 : 0) + (has_wb ? 1 : 0);
    exp_dreq = is_mem ? dw + 1 : 0;
    exp_we   = (t == T_STORE) ? dw + 1 : 0;
    exp_rw   = (has_wb && rd != 0) ? 1 : 0;
    exp_ps   = (t == T_BRANCH) ? int'(tk) : (is_jump ? 1 : 0);
    exp_wbs  = (t == T_LOAD) ? 1 : is_jump ? 2 : (t == T_LUI) ? 3 : 0;
    if (done) exp_instret++;
    checks++; if (!done) begin errors++; $display("FAIL %s retire_timeout got 0 exp 1", nm); end
    checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL %s cycles got %0d exp %0d", nm, cyc, exp_cyc); end
    checks++; if (dc != exp_dreq) begin errors++; $display("FAIL %s dmem_req_cycles got %0d exp %0d", nm, dc, exp_dreq); end
    checks++; if (wec != exp_we) begin errors++; $display("FAIL %s dmem_we_cycles got %0d exp %0d", nm, wec, exp_we); end
    checks++; if (rwc != exp_rw) begin errors++; $display("FAIL %s reg_write got %0d exp %0d", nm, rwc, exp_rw); end
    checks++; if (irl != 1 || rfr != 1 || alu != 1) begin errors++;
      $display("FAIL %s ir_load/rf_read/alu_en got %0d/%0d/%0d exp 1/1/1", nm, irl, rfr, alu); end
    checks++; if (ps != exp_ps) begin errors++; $display("FAIL %s pc_src got %0d exp %0d", nm, ps, exp_ps); end
    checks++; if (wbs != exp_wbs) begin errors++; $display("FAIL %s wb_sel got %0d exp %0d", nm, wbs, exp_wbs); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL %s instret got %0d exp %0d", nm, instret, exp_instret); end
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL %s trap got %0b exp 0", nm, trap); end
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_req, ir_load, rf_read, alu_en, dmem_req, dmem_we, reg_write, wb_sel,
         pc_write, pc_src, trap, trap_cause, instret} !== '0) begin
      errors++; $display("FAIL %s outputs_in_reset got nonzero exp 0", nm);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || instret !== 32'd0 || trap !== 1'b0) begin
      errors++; $display("FAIL %s after_reset imem_req/instret/trap got %0b/%0d/%0b exp 1/0/0",
                         nm, imem_req, instret, trap);
    end
    @(posedge clk); #1;
    // bench is one cycle into FETCH; re-reset cheaply by re-entering from a clean edge
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
  endtask

  // Runs until trap; iw/dw < 0 means that ready never arrives
  task automatic run_trap(input int t, input logic valid, input logic [6:0] opc, input int iw,
                          input int dw, input int exp_cause, input int exp_cyc, input string nm);
    int cyc = 0, ic = 0, dc = 0;
    logic [31:0] held;
    set_instr(t, 5'd1, 1'b0);
    opcode_valid = valid;
    opcode       = opc;
    held         = exp_instret;
    imem_ready   = (iw == 0);
    dmem_ready   = (dw == 0);
    #1;
    while (!trap && cyc < 100) begin
      cyc++;
      if (imem_req) ic++;
      if (dmem_req) dc++;
      @(posedge clk); #1;
      imem_ready = (iw >= 0 && ic == iw);
      dmem_ready = (dw >= 0 && dc == dw);
      #1;
    end
    checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL %s cycles_to_trap got %0d exp %0d", nm, cyc, exp_cyc); end
    checks++; if (trap_cause !== 3'(exp_cause)) begin errors++;
      $display("FAIL %s trap_cause got %0d exp %0d", nm, trap_cause, exp_cause); end
    for (int k = 0; k < 5; k++) begin
      imem_ready   = 1'($urandom);
      dmem_ready   = 1'($urandom);
      opcode_valid = 1'($urandom);
      #1;
      checks++;
      if (trap !== 1'b1 || {imem_req, ir_load, rf_read, alu_en, dmem_req, dmem_we, reg_write,
                            wb_sel, pc_write, pc_src} !== '0 || trap_cause !== 3'(exp_cause)
          || instret !== held) begin
        errors++; $display("FAIL %s trap_quiescent trap=%0b cause=%0d instret=%0d exp 1/%0d/%0d",
                           nm, trap, trap_cause, instret, exp_cause, held);
      end
      @(posedge clk); #1;
    end
    do_reset({nm, "_reset"});
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_basic();
    run_instr(T_ALUI, 5'd1, 1'b0, 0, 0, "addi_x1");
    run_instr(T_LOAD, 5'd5, 1'b0, 0, 3, "lw_x5_wait3");
    run_instr(T_BRANCH, 5'd0, 1'b1, 0, 0, "beq_taken");
    run_instr(T_BRANCH, 5'd0, 1'b0, 0, 0, "beq_not_taken");
    run_instr(T_ALUI, 5'd0, 1'b0, 0, 0, "addi_x0");
    run_instr(T_STORE, 5'd0, 1'b0, 0, 0, "sw");
    run_instr(T_FENCE, 5'd0, 1'b0, 0, 0, "fence");
    run_instr(T_JAL, 5'd1, 1'b0, 0, 0, "jal");
    run_instr(T_LUI, 5'd3, 1'b0, 0, 0, "lui");
    run_instr(T_AUIPC, 5'd4, 1'b0, 0, 0, "auipc");
  endtask

  task automatic test_timeout_boundary();
    run_instr(T_ALU, 5'd2, 1'b0, TIMEOUT - 1, 0, "fetch_wait_last");
    run_instr(T_LOAD, 5'd2, 1'b0, 0, TIMEOUT - 1, "load_wait_last");
  endtask

  task automatic test_traps();
    run_trap(T_ALU, 1'b1, 7'h33, -1, 0, 1, TIMEOUT, "fetch_timeout");
    run_instr(T_ALUI, 5'd1, 1'b0, 0, 0, "addi_before_illegal");
    run_trap(T_ALU, 1'b0, 7'h7F, 1, 0, 2, 3, "illegal");
    run_trap(T_SYSTEM, 1'b1, 7'h73, 0, 0, 3, 2, "system");
    run_trap(T_LOAD, 1'b1, 7'h03, 2, -1, 4, 3 + 2 + TIMEOUT, "data_timeout");
  endtask

  task automatic test_reset_mid_mem();
    int n = 0;
    run_instr(T_ALU, 5'd7, 1'b0, 0, 0, "alu_before_sw");
    set_instr(T_STORE, 5'd0, 1'b0);
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    #1;
    while (!dmem_req && n < 10) begin n++; @(posedge clk); #1; end
    checks++; if (!dmem_req) begin errors++; $display("FAIL mid_mem reach_mem got 0 exp 1"); end
    reset = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || instret !== 32'd0) begin errors++;
      $display("FAIL mid_mem reset_cycle dmem_req/dmem_we/instret got %0b/%0b/%0d exp 0/0/0",
               dmem_req, dmem_we, instret); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 0;
    dmem_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || dmem_req !== 1'b0 || instret !== 32'd0) begin errors++;
      $display("FAIL mid_mem resume imem_req/dmem_req/instret got %0b/%0b/%0d exp 1/0/0",
               imem_req, dmem_req, instret); end
    @(posedge clk); #1;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      run_instr($urandom_range(0, 9), 5'($urandom), 1'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4), "random");
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = '0; inst_type = '0; rd_addr = '0; opcode_valid = 1'b0;
    branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_basic();
    test_timeout_boundary();
    test_traps();
    test_reset_mid_mem();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
